// File: rtl/rational_resampler_5_3_pkg.sv
// Shared constants and FSM state type for the 5/3 polyphase resampler.
package resampler_pkg;

  localparam int L         = 5;   // interpolation factor (number of phases)
  localparam int M         = 3;   // decimation factor (phase step per output)
  localparam int TAPS      = 8;   // taps per phase
  localparam int COEF_FRAC = 17;  // Q1.17 coefficients
  localparam int ACC_W     = 37;  // accumulator width

  typedef enum logic [1:0] {
    WAIT_IN,
    MAC,
    OUT
  } state_t;

endpackage

// File: rtl/rational_resampler_5_3_if.sv
// Sample-in / sample-out handshakes plus the read-only coefficient RAM port.
interface rational_resampler_5_3_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);

  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [ADDR_W-1:0]        coef_address;
  logic                     coef_clken;
  logic [31:0]              coef_readdata;

  // Environment side: sample source, sink and coefficient RAM.
  modport master (
    output in_data, in_valid, out_ready, coef_readdata,
    input  in_ready, out_data, out_valid, coef_address, coef_clken
  );

  // Resampler side.
  modport slave (
    input  in_data, in_valid, out_ready, coef_readdata,
    output in_ready, out_data, out_valid, coef_address, coef_clken
  );

endinterface

// File: rtl/rational_resampler_5_3_mac.sv
// Signed multiply-accumulate with round-half-up and saturation to DATA_W.
module resampler_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 18
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_en,
  input  logic                     i_done,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [COEF_W-1:0] i_coef,
  output logic signed [DATA_W-1:0] o_result
);
  import resampler_pkg::*;

  localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [DATA_W+COEF_W-1:0] w_prod;
  logic signed [ACC_W-1:0]         w_sum;
  logic signed [ACC_W-1:0]         r_acc;
  logic signed [DATA_W-1:0]        r_result;

  function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = (a + HALF) >>> COEF_FRAC;
    if (s > SAT_MAX) return SAT_MAX[DATA_W-1:0];
    if (s < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    return s[DATA_W-1:0];
  endfunction

  assign w_prod   = i_x * i_coef;
  assign w_sum    = r_acc + ACC_W'(w_prod);
  assign o_result = r_result;

  // Accumulate one tap product per enabled cycle; cleared at the start of each output.
  always_ff @(posedge i_clk) begin
    if (i_clear)   r_acc <= '0;
    else if (i_en) r_acc <= w_sum;
  end

  // The final product bypasses the accumulator straight into the rounded output register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)               r_result <= '0;
    else if (i_en && i_done) r_result <= round_sat(w_sum);
  end

endmodule

// File: rtl/rational_resampler_5_3.sv
// 5/3 polyphase resampler: FSM, phase stepping and delay line; MAC in resampler_mac.
module rational_resampler_5_3 #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 18,
  parameter int TAPS   = 8,
  parameter int ADDR_W = 6
) (
  input logic clk,
  input logic reset,
  rational_resampler_5_3_if.slave bus
);
  import resampler_pkg::*;

  localparam int                K_W    = $clog2(TAPS + 1);
  localparam int                X_W    = $clog2(TAPS);
  localparam logic [K_W-1:0]    K_LAST = K_W'(TAPS);
  localparam logic [2:0]        PH_L   = 3'(L);
  localparam logic [2:0]        PH_M   = 3'(M);
  localparam logic [ADDR_W-1:0] A_L    = ADDR_W'(L);

  state_t                   r_state, w_state_nxt;
  logic [2:0]               r_p, w_p_nxt, w_pn;
  logic [K_W-1:0]           r_k;
  logic signed [DATA_W-1:0] r_x [TAPS];
  logic signed [DATA_W-1:0] r_x_p1;
  logic                     r_vld_p1, r_last_p1;
  logic                     w_accept, w_clear;
  logic                     w_coef_clken;
  logic [ADDR_W-1:0]        w_coef_address;
  logic signed [COEF_W-1:0] w_coef;
  logic signed [DATA_W-1:0] w_result;
  logic                     w_unused_coef_hi;

  assign w_pn             = r_p + PH_M;
  assign w_coef           = $signed(bus.coef_readdata[COEF_W-1:0]);
  assign w_unused_coef_hi = ^bus.coef_readdata[31:COEF_W];

  // Next-state, phase advance and handshake/RAM-port outputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_p_nxt        = r_p;
    w_accept       = 1'b0;
    w_clear        = 1'b0;
    w_coef_clken   = 1'b0;
    w_coef_address = '0;
    bus.in_ready   = 1'b0;
    bus.out_valid  = 1'b0;
    unique case (r_state)
      WAIT_IN: begin
        bus.in_ready = ~reset;
        if (bus.in_valid && !reset) begin
          w_accept    = 1'b1;
          w_clear     = 1'b1;
          w_state_nxt = MAC;
        end
      end
      MAC: begin
        if (r_k < K_LAST) begin
          w_coef_clken   = 1'b1;
          w_coef_address = A_L * ADDR_W'(r_k) + ADDR_W'(r_p);
        end else begin
          w_state_nxt = OUT;
        end
      end
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          if (w_pn >= PH_L) begin
            w_p_nxt     = w_pn - PH_L;
            w_state_nxt = WAIT_IN;
          end else begin
            w_p_nxt     = w_pn;
            w_clear     = 1'b1;
            w_state_nxt = MAC;
          end
        end
      end
      default: w_state_nxt = WAIT_IN;
    endcase
  end

  // Control state: FSM, phase, tap counter and the valid/last flags riding with each RAM read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= WAIT_IN;
      r_p       <= '0;
      r_k       <= '0;
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_p       <= w_p_nxt;
      if (w_clear)                            r_k <= '0;
      else if (r_state == MAC && r_k < K_LAST) r_k <= r_k + K_W'(1);
      // p0 -> p1: RAM latches the address while the matching tap sample is registered.
      r_vld_p1  <= w_coef_clken;
      r_last_p1 <= w_coef_clken && (r_k == K_LAST - K_W'(1));
    end
  end

  // Delay line starts from an all-zero history; newest sample enters at x[0].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) r_x[i] <= '0;
    end else if (w_accept) begin
      for (int i = TAPS - 1; i > 0; i--) r_x[i] <= r_x[i-1];
      r_x[0] <= bus.in_data;
    end
  end

  // Tap sample aligned with the RAM's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (w_coef_clken) r_x_p1 <= r_x[r_k[X_W-1:0]];
  end

  resampler_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W)
  ) u_mac (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_clear  (w_clear),
    .i_en     (r_vld_p1),
    .i_done   (r_last_p1),
    .i_x      (r_x_p1),
    .i_coef   (w_coef),
    .o_result (w_result)
  );

  assign bus.out_data     = w_result;
  assign bus.coef_address = w_coef_address;
  assign bus.coef_clken   = w_coef_clken;

endmodule

// File: tb/tb_rational_resampler_5_3.sv
// Directed bench for the 5/3 resampler with a queue scoreboard and a coefficient RAM model.
module tb_rational_resampler_5_3;

  logic clk = 1'b0;
  logic reset;

  rational_resampler_5_3_if #(.DATA_W(16), .ADDR_W(6)) bus ();

  rational_resampler_5_3 #(
    .DATA_W (16),
    .COEF_W (18),
    .TAPS   (8),
    .ADDR_W (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Coefficient RAM second port: registered address, unregistered read data.
  logic [31:0] mem [40];
  logic [5:0]  ram_addr = '0;
  always @(posedge clk) if (bus.coef_clken) ram_addr <= bus.coef_address;
  assign bus.coef_readdata = mem[ram_addr];

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;
  int exp_q[$];
  int addr_q[$];
  int got_q[$];
  int mx[8];
  int mp;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint cval(input int a);
    logic [17:0] c;
    c = mem[a][17:0];
    return longint'($signed(c));
  endfunction

  function automatic int model_out(input int p);
    longint acc;
    longint r;
    acc = 0;
    for (int k = 0; k < 8; k++) acc += longint'(mx[k]) * cval(5 * k + p);
    r = (acc + 65536) >>> 17;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) mx[k] = 0;
    mp = 0;
    exp_q.delete();
    addr_q.delete();
  endtask

  // Shift the model delay line and push every output (and its 8 addresses) until the next input is needed.
  task automatic model_push(input int d);
    bit more;
    int pn;
    for (int k = 7; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = d;
    more = 1'b1;
    while (more) begin
      exp_q.push_back(model_out(mp));
      for (int k = 0; k < 8; k++) addr_q.push_back(5 * k + mp);
      pn = mp + 3;
      if (pn >= 5) begin
        mp   = pn - 5;
        more = 1'b0;
      end else begin
        mp = pn;
      end
    end
  endtask

  task automatic send(input int d);
    int n;
    bus.in_data  = 16'(d);
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", bus.in_ready, 1);
    model_push(d);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #2 reset = 1'b1;
    model_reset();
    got_q.delete();
    #4 reset = 1'b0;
    #1;
  endtask

  // Output/address monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("ready_valid_excl", bus.in_ready & bus.out_valid, 0);
      if (bus.coef_clken === 1'b1) begin
        check("in_ready_in_mac", bus.in_ready, 0);
        check("addr_avail", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) check("coef_address", bus.coef_address, addr_q.pop_front());
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        check("out_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("out_data", bus.out_data, exp_q.pop_front());
        got_q.push_back(int'(bus.out_data));
        n_out++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n0;
    logic signed [15:0] hold;

    reset        = 1'b1;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int a = 0; a < 40; a++) mem[a] = 32'(a * 256);
    model_reset();

    // Reset values
    #12;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_coef_address", bus.coef_address, 0);
    check("rst_coef_clken", bus.coef_clken, 0);
    #5 reset = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    // Impulse: output j reads coefficient 3j, giving 96*j
    got_q.delete();
    send(16384);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("first_latency", n, 10);
    for (int i = 0; i < 7; i++) send(0);
    drain();
    check("impulse_count", got_q.size(), 14);
    for (int j = 0; j < 14; j++) check("impulse_out", got_q[j], 96 * j);

    // Asynchronous reset in the middle of a MAC
    send(1234);
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_in_ready", bus.in_ready, 0);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_data", bus.out_data, 0);
    check("mid_rst_coef_address", bus.coef_address, 0);
    check("mid_rst_coef_clken", bus.coef_clken, 0);
    model_reset();
    got_q.delete();
    #3 reset = 1'b0;
    #1;
    check("mid_rst_release_ready", bus.in_ready, 1);
    send(777);
    check("restart_addr0", bus.coef_address, 0);
    check("restart_clken", bus.coef_clken, 1);
    drain();

    // DC gain: 8 taps x 0.5 x 1000
    for (int a = 0; a < 40; a++) mem[a] = 32'h0001_0000;
    reset_dut();
    for (int i = 0; i < 12; i++) send(1000);
    drain();
    check("dc_count", got_q.size(), 20);
    for (int i = 12; i < 20; i++) check("dc_gain", got_q[i], 4000);

    // Rate: 30 inputs produce exactly 50 outputs
    n0 = n_out;
    for (int i = 0; i < 30; i++) send($urandom_range(0, 40000) - 20000);
    drain();
    check("rate_outputs", n_out - n0, 50);

    // Backpressure: OUT holds with the RAM port idle
    send(500);
    bus.out_ready = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_reach_out", bus.out_valid, 1);
    hold = bus.out_data;
    repeat (20) begin
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_data", bus.out_data, hold);
      check("bp_coef_clken", bus.coef_clken, 0);
      check("bp_in_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    drain();

    // Saturation at both rails
    for (int a = 0; a < 40; a++) mem[a] = 32'd131071;
    reset_dut();
    for (int i = 0; i < 8; i++) send(32767);
    drain();
    check("sat_pos", got_q[got_q.size() - 1], 32767);
    reset_dut();
    for (int i = 0; i < 8; i++) send(-32768);
    drain();
    check("sat_neg", got_q[got_q.size() - 1], -32768);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
